// File: rtl/if_hazard_pkg.sv
// Shared types and constants for the fetch-stage hazard controller.
// The canned control words keep the FSM body readable and the output encoding in one place.
package if_hazard_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } ctrl_state_t;

  localparam logic [4:0] REG_X0 = 5'd0;

  typedef struct packed {
    logic pc_write;
    logic write_ifid;
    logic flush_if;
    logic flush_idex;
  } ctrl_out_t;

  localparam ctrl_out_t CTRL_BOOT       = 4'b0011;
  localparam ctrl_out_t CTRL_FREEZE     = 4'b0000;
  localparam ctrl_out_t CTRL_REDIRECT   = 4'b1111;
  localparam ctrl_out_t CTRL_LOAD_STALL = 4'b0001;
  localparam ctrl_out_t CTRL_NORMAL     = 4'b1100;
  localparam ctrl_out_t CTRL_BUBBLE     = 4'b1110;

endpackage

// File: rtl/if_hazard_ctrl_load_use_detect.sv
// Combinational load-use comparator: the ID instruction reads a register that the load in EX
// is about to write. A destination of x0 never creates a dependency.
module load_use_detect
  import if_hazard_pkg::*;
(
  input  logic       memread_ex,
  input  logic [4:0] rd_ex,
  input  logic [4:0] rs1_id,
  input  logic [4:0] rs2_id,
  input  logic       rs1_used_id,
  input  logic       rs2_used_id,
  output logic       load_use
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit  = rs1_used_id && (rs1_id == rd_ex);
  assign rs2_hit  = rs2_used_id && (rs2_id == rd_ex);
  assign load_use = memread_ex && (rd_ex != REG_X0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/if_hazard_ctrl.sv
// Front-end hazard controller: boot priming, redirect bubbles, load-use stalls and memory freeze,
// plus saturating stall/redirect counters for performance debug.
module if_hazard_ctrl
  import if_hazard_pkg::*;
#(
  parameter int BOOT_CYCLES      = 2,
  parameter int REDIRECT_BUBBLES = 1,
  parameter int CNT_W            = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       rs1_id,
  input  logic [4:0]       rs2_id,
  input  logic             rs1_used_id,
  input  logic             rs2_used_id,
  input  logic [4:0]       rd_ex,
  input  logic             memread_ex,
  input  logic             pcsrc_ex,
  input  logic             mem_busy,
  output logic             pc_write,
  output logic             write_ifid,
  output logic             flush_if,
  output logic             flush_idex,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int BUB_MAX = (BOOT_CYCLES > REDIRECT_BUBBLES) ? BOOT_CYCLES : REDIRECT_BUBBLES;
  localparam int BUB_W   = (BUB_MAX < 2) ? 1 : $clog2(BUB_MAX + 1);
  localparam logic [BUB_W-1:0] BUB_BOOT     = BUB_W'(BOOT_CYCLES);
  localparam logic [BUB_W-1:0] BUB_REDIRECT = BUB_W'(REDIRECT_BUBBLES);
  localparam logic [BUB_W-1:0] BUB_LAST     = BUB_W'(1);

  ctrl_state_t      state_reg;
  ctrl_state_t      state_next;
  logic [BUB_W-1:0] bub_cnt_reg;
  logic [BUB_W-1:0] bub_cnt_next;
  ctrl_out_t        ctrl;
  logic             stall_inc;
  logic             flush_inc;
  logic             load_use;

  load_use_detect u_load_use_detect (
    .memread_ex  (memread_ex),
    .rd_ex       (rd_ex),
    .rs1_id      (rs1_id),
    .rs2_id      (rs2_id),
    .rs1_used_id (rs1_used_id),
    .rs2_used_id (rs2_used_id),
    .load_use    (load_use)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= BOOT;
      bub_cnt_reg <= BUB_BOOT;
    end else begin
      state_reg   <= state_next;
      bub_cnt_reg <= bub_cnt_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    bub_cnt_next = bub_cnt_reg;
    ctrl         = CTRL_BOOT;
    stall_inc    = 1'b0;
    flush_inc    = 1'b0;

    unique case (state_reg)
      BOOT: begin
        ctrl         = CTRL_BOOT;
        bub_cnt_next = bub_cnt_reg - 1'b1;
        if (bub_cnt_reg <= BUB_LAST) begin
          state_next = RUN;
        end
      end

      RUN: begin
        if (mem_busy) begin
          ctrl      = CTRL_FREEZE;
          stall_inc = 1'b1;
        end else if (pcsrc_ex) begin
          ctrl      = CTRL_REDIRECT;
          flush_inc = 1'b1;
          if (REDIRECT_BUBBLES > 0) begin
            state_next   = FLUSH;
            bub_cnt_next = BUB_REDIRECT;
          end
        end else if (load_use) begin
          ctrl      = CTRL_LOAD_STALL;
          stall_inc = 1'b1;
        end else begin
          ctrl = CTRL_NORMAL;
        end
      end

      FLUSH: begin
        // ID holds a NOP here, so load_use cannot be real and is not consulted.
        if (mem_busy) begin
          ctrl      = CTRL_FREEZE;
          stall_inc = 1'b1;
        end else if (pcsrc_ex) begin
          ctrl      = CTRL_REDIRECT;
          flush_inc = 1'b1;
          if (REDIRECT_BUBBLES > 0) begin
            bub_cnt_next = BUB_REDIRECT;
          end else begin
            state_next = RUN;
          end
        end else begin
          ctrl         = CTRL_BUBBLE;
          bub_cnt_next = bub_cnt_reg - 1'b1;
          if (bub_cnt_reg <= BUB_LAST) begin
            state_next = RUN;
          end
        end
      end

      default: begin
        state_next   = BOOT;
        bub_cnt_next = BUB_BOOT;
      end
    endcase
  end

  assign pc_write   = ctrl.pc_write;
  assign write_ifid = ctrl.write_ifid;
  assign flush_if   = ctrl.flush_if;
  assign flush_idex = ctrl.flush_idex;

  // Index 0 counts stall cycles, index 1 counts redirects.
  logic [1:0]         cnt_inc;
  logic [2*CNT_W-1:0] cnt_flat;

  assign cnt_inc = {flush_inc, stall_inc};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      logic [CNT_W-1:0] count_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          count_reg <= '0;
        end else if (cnt_inc[gi] && (count_reg != {CNT_W{1'b1}})) begin
          count_reg <= count_reg + 1'b1;
        end
      end

      assign cnt_flat[gi*CNT_W +: CNT_W] = count_reg;
    end
  endgenerate

  assign stall_cnt = cnt_flat[0 +: CNT_W];
  assign flush_cnt = cnt_flat[CNT_W +: CNT_W];

endmodule

// File: tb/tb_if_hazard_ctrl.sv
// Directed bench for if_hazard_ctrl with BOOT_CYCLES=2, REDIRECT_BUBBLES=1, CNT_W=4.
// Inputs change on the falling edge; outputs are sampled 1ns later, away from the rising edge.
module tb_if_hazard_ctrl;

  localparam int CNT_W = 4;
  localparam int CNT_MAX = 15;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [4:0]       rs1_id = '0;
  logic [4:0]       rs2_id = '0;
  logic             rs1_used_id = 1'b0;
  logic             rs2_used_id = 1'b0;
  logic [4:0]       rd_ex = '0;
  logic             memread_ex = 1'b0;
  logic             pcsrc_ex = 1'b0;
  logic             mem_busy = 1'b0;
  logic             pc_write;
  logic             write_ifid;
  logic             flush_if;
  logic             flush_idex;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  logic [3:0] ctl;
  int checks = 0;
  int errors = 0;
  int exp_stall = 0;
  int exp_flush = 0;

  assign ctl = {pc_write, write_ifid, flush_if, flush_idex};

  if_hazard_ctrl #(
    .BOOT_CYCLES      (2),
    .REDIRECT_BUBBLES (1),
    .CNT_W            (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rs1_id      (rs1_id),
    .rs2_id      (rs2_id),
    .rs1_used_id (rs1_used_id),
    .rs2_used_id (rs2_used_id),
    .rd_ex       (rd_ex),
    .memread_ex  (memread_ex),
    .pcsrc_ex    (pcsrc_ex),
    .mem_busy    (mem_busy),
    .pc_write    (pc_write),
    .write_ifid  (write_ifid),
    .flush_if    (flush_if),
    .flush_idex  (flush_idex),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic set_in(input logic busy, input logic pcsrc, input logic memread,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2);
    mem_busy    = busy;
    pcsrc_ex    = pcsrc;
    memread_ex  = memread;
    rd_ex       = rd;
    rs1_id      = rs1;
    rs1_used_id = u1;
    rs2_id      = rs2;
    rs2_used_id = u2;
  endtask

  task automatic idle();
    set_in(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    @(negedge clk); #1;
    checks++; if (ctl !== 4'b0011) begin errors++; $display("FAIL reset_ctl: got %b expected 0011", ctl); end
    checks++; if (stall_cnt !== 4'd0) begin errors++; $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cnt); end
    checks++; if (flush_cnt !== 4'd0) begin errors++; $display("FAIL reset_flush_cnt: got %0d expected 0", flush_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    set_in(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    #1;
    checks++; if (ctl !== 4'b0011) begin errors++; $display("FAIL boot_cycle1: got %b expected 0011", ctl); end
    @(negedge clk);
    set_in(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    #1;
    checks++; if (ctl !== 4'b0011) begin errors++; $display("FAIL boot_cycle2: got %b expected 0011", ctl); end
    @(negedge clk);
    idle();
    #1;
    checks++; if (ctl !== 4'b1100) begin errors++; $display("FAIL boot_cycle3_run: got %b expected 1100", ctl); end
    checks++; if (stall_cnt !== 4'd0) begin errors++; $display("FAIL boot_stall_ignored: got %0d expected 0", stall_cnt); end
    checks++; if (flush_cnt !== 4'd0) begin errors++; $display("FAIL boot_flush_ignored: got %0d expected 0", flush_cnt); end
  endtask

  task automatic test_load_use();
    @(negedge clk);
    set_in(1'b0, 1'b0, 1'b1, 5'd5, 5'd0, 1'b0, 5'd5, 1'b1);
    #1;
    checks++; if (ctl !== 4'b0001) begin errors++; $display("FAIL load_use_rs2: got %b expected 0001", ctl); end
    exp_stall++;
    @(negedge clk);
    idle();
    #1;
    checks++; if (ctl !== 4'b1100) begin errors++; $display("FAIL load_use_release: got %b expected 1100", ctl); end
    checks++; if (stall_cnt !== 4'(exp_stall)) begin errors++; $display("FAIL load_use_stall_cnt: got %0d expected %0d", stall_cnt, exp_stall); end
    @(negedge clk);
    set_in(1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
    #1;
    checks++; if (ctl !== 4'b1100) begin errors++; $display("FAIL load_use_x0: got %b expected 1100", ctl); end
    @(negedge clk);
    set_in(1'b0, 1'b0, 1'b1, 5'd5, 5'd7, 1'b1, 5'd5, 1'b0);
    #1;
    checks++; if (ctl !== 4'b1100) begin errors++; $display("FAIL load_use_rs2_unused: got %b expected 1100", ctl); end
    @(negedge clk);
    set_in(1'b0, 1'b0, 1'b0, 5'd5, 5'd0, 1'b0, 5'd5, 1'b1);
    #1;
    checks++; if (ctl !== 4'b1100) begin errors++; $display("FAIL load_use_not_load: got %b expected 1100", ctl); end
    @(negedge clk);
    set_in(1'b0, 1'b0, 1'b1, 5'd9, 5'd9, 1'b1, 5'd3, 1'b1);
    #1;
    checks++; if (ctl !== 4'b0001) begin errors++; $display("FAIL load_use_rs1: got %b expected 0001", ctl); end
    exp_stall++;
    @(negedge clk);
    idle();
    #1;
    checks++; if (stall_cnt !== 4'(exp_stall)) begin errors++; $display("FAIL load_use_stall_cnt2: got %0d expected %0d", stall_cnt, exp_stall); end
  endtask

  task automatic test_redirect();
    @(negedge clk);
    set_in(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    #1;
    checks++; if (ctl !== 4'b1111) begin errors++; $display("FAIL redirect_cycle0: got %b expected 1111", ctl); end
    exp_flush++;
    @(negedge clk);
    set_in(1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
    #1;
    checks++; if (ctl !== 4'b1110) begin errors++; $display("FAIL redirect_cycle1: got %b expected 1110", ctl); end
    checks++; if (flush_cnt !== 4'(exp_flush)) begin errors++; $display("FAIL redirect_flush_cnt: got %0d expected %0d", flush_cnt, exp_flush); end
    @(negedge clk);
    idle();
    #1;
    checks++; if (ctl !== 4'b1100) begin errors++; $display("FAIL redirect_cycle2: got %b expected 1100", ctl); end
    checks++; if (stall_cnt !== 4'(exp_stall)) begin errors++; $display("FAIL redirect_load_use_ignored: got %0d expected %0d", stall_cnt, exp_stall); end
  endtask

  task automatic test_simultaneous();
    @(negedge clk);
    set_in(1'b1, 1'b1, 1'b1, 5'd3, 5'd0, 1'b0, 5'd3, 1'b1);
    #1;
    checks++; if (ctl !== 4'b0000) begin errors++; $display("FAIL simul_freeze: got %b expected 0000", ctl); end
    exp_stall++;
    @(negedge clk);
    mem_busy = 1'b0;
    #1;
    checks++; if (ctl !== 4'b1111) begin errors++; $display("FAIL simul_redirect_taken: got %b expected 1111", ctl); end
    checks++; if (stall_cnt !== 4'(exp_stall)) begin errors++; $display("FAIL simul_stall_cnt: got %0d expected %0d", stall_cnt, exp_stall); end
    checks++; if (flush_cnt !== 4'(exp_flush)) begin errors++; $display("FAIL simul_flush_unchanged: got %0d expected %0d", flush_cnt, exp_flush); end
    exp_flush++;
    @(negedge clk);
    idle();
    #1;
    checks++; if (ctl !== 4'b1110) begin errors++; $display("FAIL simul_bubble: got %b expected 1110", ctl); end
    checks++; if (flush_cnt !== 4'(exp_flush)) begin errors++; $display("FAIL simul_flush_cnt: got %0d expected %0d", flush_cnt, exp_flush); end
    @(negedge clk); #1;
    checks++; if (ctl !== 4'b1100) begin errors++; $display("FAIL simul_run: got %b expected 1100", ctl); end
  endtask

  task automatic test_freeze_in_flush();
    @(negedge clk);
    set_in(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    #1;
    checks++; if (ctl !== 4'b1111) begin errors++; $display("FAIL ff_redirect: got %b expected 1111", ctl); end
    exp_flush++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      set_in(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
      #1;
      checks++; if (ctl !== 4'b0000) begin errors++; $display("FAIL ff_freeze_%0d: got %b expected 0000", i, ctl); end
      exp_stall++;
    end
    @(negedge clk);
    idle();
    #1;
    checks++; if (ctl !== 4'b1110) begin errors++; $display("FAIL ff_bubble_held: got %b expected 1110", ctl); end
    checks++; if (stall_cnt !== 4'(exp_stall)) begin errors++; $display("FAIL ff_stall_cnt: got %0d expected %0d", stall_cnt, exp_stall); end
    @(negedge clk); #1;
    checks++; if (ctl !== 4'b1100) begin errors++; $display("FAIL ff_run: got %b expected 1100", ctl); end
    checks++; if (flush_cnt !== 4'(exp_flush)) begin errors++; $display("FAIL ff_flush_cnt: got %0d expected %0d", flush_cnt, exp_flush); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    set_in(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    #1;
    checks++; if (ctl !== 4'b1111) begin errors++; $display("FAIL b2b_first: got %b expected 1111", ctl); end
    exp_flush++;
    @(negedge clk); #1;
    checks++; if (ctl !== 4'b1111) begin errors++; $display("FAIL b2b_second_in_flush: got %b expected 1111", ctl); end
    exp_flush++;
    @(negedge clk);
    idle();
    #1;
    checks++; if (ctl !== 4'b1110) begin errors++; $display("FAIL b2b_bubble: got %b expected 1110", ctl); end
    checks++; if (flush_cnt !== 4'(exp_flush)) begin errors++; $display("FAIL b2b_flush_cnt: got %0d expected %0d", flush_cnt, exp_flush); end
    @(negedge clk); #1;
    checks++; if (ctl !== 4'b1100) begin errors++; $display("FAIL b2b_run: got %b expected 1100", ctl); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 0) set_in(1'b0, 1'b0, 1'b1, 5'd6, 5'd0, 1'b0, 5'd6, 1'b1);
      #1;
      checks++; if (ctl !== 4'b0001) begin errors++; $display("FAIL sat_stall_%0d: got %b expected 0001", i, ctl); end
      checks++; if (stall_cnt !== 4'(exp_stall)) begin errors++; $display("FAIL sat_cnt_%0d: got %0d expected %0d", i, stall_cnt, exp_stall); end
      if (exp_stall < CNT_MAX) exp_stall++;
    end
    @(negedge clk);
    idle();
    #1;
    checks++; if (stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_final: got %0d expected 15", stall_cnt); end
    checks++; if (ctl !== 4'b1100) begin errors++; $display("FAIL sat_run: got %b expected 1100", ctl); end
  endtask

  task automatic test_reset_mid_flush();
    @(negedge clk);
    set_in(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    #1;
    checks++; if (ctl !== 4'b1111) begin errors++; $display("FAIL rmf_redirect: got %b expected 1111", ctl); end
    @(negedge clk);
    idle();
    rst_n = 1'b0;
    #1;
    checks++; if (ctl !== 4'b0011) begin errors++; $display("FAIL rmf_async_boot: got %b expected 0011", ctl); end
    checks++; if (stall_cnt !== 4'd0) begin errors++; $display("FAIL rmf_stall_clr: got %0d expected 0", stall_cnt); end
    checks++; if (flush_cnt !== 4'd0) begin errors++; $display("FAIL rmf_flush_clr: got %0d expected 0", flush_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (ctl !== 4'b0011) begin errors++; $display("FAIL rmf_boot1: got %b expected 0011", ctl); end
    @(negedge clk); #1;
    checks++; if (ctl !== 4'b0011) begin errors++; $display("FAIL rmf_boot2: got %b expected 0011", ctl); end
    @(negedge clk); #1;
    checks++; if (ctl !== 4'b1100) begin errors++; $display("FAIL rmf_run: got %b expected 1100", ctl); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_load_use();
    test_redirect();
    test_simultaneous();
    test_freeze_in_flush();
    test_back_to_back();
    test_saturation();
    test_reset_mid_flush();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
